// File: rtl/mod47_mul_seq.sv
// rtl/mod47_mul_seq.sv - sequential (A*B) mod MODULUS multiplier using one shared 3x3 partial-product multiplier
module mod47_mul_seq #(
  parameter int unsigned MODULUS = 47
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] res,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP1  = 3'd1,
    PP2  = 3'd2,
    PP3  = 3'd3,
    PP4  = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [6:0] MOD7 = 7'(MODULUS);

  // Add two residues (each below 64) and fold once; valid whenever the raw sum is below 2*MODULUS.
  function automatic logic [5:0] mod_add(input logic [5:0] x, input logic [5:0] y);
    logic [6:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= MOD7) ? 6'(s - MOD7) : s[5:0];
  endfunction

  state_t     state_q, state_d;
  logic [5:0] ra_q, ra_d;
  logic [5:0] rb_q, rb_d;
  logic [5:0] acc_q, acc_d;
  logic [5:0] res_q, res_d;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       busy_q, busy_d;

  logic [2:0] mx, my;
  logic [5:0] pp, pp_red;
  logic [5:0] acc_x2, acc_x4, acc_x8;
  logic [5:0] step_mul8, step_add;

  // Route the digit pair for the current Horner step into the single shared multiplier.
  always_comb begin
    mx = ra_q[2:0];
    my = rb_q[2:0];
    case (state_q)
      PP1: begin mx = ra_q[5:3]; my = rb_q[5:3]; end
      PP2: begin mx = ra_q[5:3]; my = rb_q[2:0]; end
      PP3: begin mx = ra_q[2:0]; my = rb_q[5:3]; end
      default: begin mx = ra_q[2:0]; my = rb_q[2:0]; end
    endcase
    pp        = {3'b000, mx} * {3'b000, my};
    pp_red    = mod_add(pp, 6'd0);
    acc_x2    = mod_add(acc_q, acc_q);
    acc_x4    = mod_add(acc_x2, acc_x2);
    acc_x8    = mod_add(acc_x4, acc_x4);
    step_mul8 = mod_add(acc_x8, pp_red);
    step_add  = mod_add(acc_q, pp_red);
  end

  // Next-state and datapath updates; outputs are registered decodes of the next state.
  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ra_d    = mod_add(a, 6'd0);
          rb_d    = mod_add(b, 6'd0);
          state_d = PP1;
        end
      end
      PP1: begin
        acc_d   = pp_red;
        state_d = PP2;
      end
      PP2: begin
        acc_d   = step_mul8;
        state_d = PP3;
      end
      PP3: begin
        acc_d   = step_add;
        state_d = PP4;
      end
      PP4: begin
        acc_d       = step_mul8;
        res_d       = step_mul8;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ra_q        <= 6'd0;
      rb_q        <= 6'd0;
      acc_q       <= 6'd0;
      res_q       <= 6'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mod47_mul_seq.sv
// tb/tb_mod47_mul_seq.sv - self-checking bench for mod47_mul_seq
module tb_mod47_mul_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] a = 6'd0;
  logic [5:0] b = 6'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [5:0] res;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int exp_q[$];
  bit rand_ready = 1'b0;

  typedef struct {
    int a;
    int b;
    int exp_res;
  } vec_t;

  vec_t vecs[7];

  mod47_mul_seq #(.MODULUS(47)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res(res),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", int'(res), -1);
      end else begin
        check("result", int'(res), exp_q.pop_front());
      end
      pops++;
    end
  end

  // Random consumer backpressure for the sweep.
  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  // Issue one operation; optionally check latency and return to IDLE with out_ready held high.
  task automatic run_op(input int av, input int bv, input int expv, input bit timed);
    int n;
    wait_ready();
    a = 6'(av);
    b = 6'(bv);
    in_valid = 1'b1;
    exp_q.push_back(expv);
    tick();
    in_valid = 1'b0;
    a = 6'($urandom_range(0, 63));
    b = 6'($urandom_range(0, 63));
    if (timed) begin
      check("in_ready_drop", int'(in_ready), 0);
      n = 0;
      while (!out_valid && n < 10) begin
        tick();
        n++;
      end
      check("latency", n, 4);
      tick();
      check("in_ready_after_done", int'(in_ready), 1);
    end
  endtask

  initial begin
    vecs[0] = '{5, 7, 35};
    vecs[1] = '{46, 46, 1};
    vecs[2] = '{13, 29, 1};
    vecs[3] = '{0, 63, 0};
    vecs[4] = '{63, 63, 21};
    vecs[5] = '{47, 10, 0};
    vecs[6] = '{50, 50, 9};

    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_res", int'(res), 0);
    check("rst_busy", int'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_res, 1'b1);
    end

    // Backpressure: result held while the consumer stalls, new operands ignored.
    out_ready = 1'b0;
    wait_ready();
    a = 6'd5;
    b = 6'd7;
    in_valid = 1'b1;
    exp_q.push_back(35);
    tick();
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 10) begin
        tick();
        n++;
      end
      check("bp_latency", n, 4);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 6'd1;
      b = 6'd1;
      tick();
      check("bp_res", int'(res), 35);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_release_busy", int'(busy), 0);
    tick();
    check("bp_no_extra", int'(out_valid), 0);

    // Reset during PP2 discards the operation.
    wait_ready();
    a = 6'd9;
    b = 6'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_res", int'(res), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    run_op(2, 3, 6, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    check("midrst_queue_empty", exp_q.size(), 0);

    // Exhaustive sweep with random stalls.
    pops = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        run_op(i, j, (i * j) % 47, 1'b0);
      end
    end
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        tick();
        n++;
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("sweep_count", pops, 4096);
    check("sweep_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
